// File: rtl/control_partida.sv
// Game-flow controller: IDLE/JUGANDO/CHOQUE/FIN sequencing, BCD score and persistent high score.
// All outputs are registered or decoded from the state register only.
module control_partida #(
  parameter int T_CHOQUE = 50_000_000,
  parameter int CW       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnInicio,
  input  logic       ciclo,
  input  logic       chocar,
  output logic [1:0] estado,
  output logic       congelar,
  output logic       reinicioJuego,
  output logic [3:0] unidades,
  output logic [3:0] decenas,
  output logic [3:0] centenas,
  output logic [3:0] unidadesMillar,
  output logic [3:0] recU,
  output logic [3:0] recD,
  output logic [3:0] recC,
  output logic [3:0] recM,
  output logic       nuevoRecord
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    JUGANDO = 2'b01,
    CHOQUE  = 2'b10,
    FIN     = 2'b11
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(T_CHOQUE - 1);

  state_t        state_q, state_d;
  logic          btn_prev_q, ciclo_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   rec_q, rec_d;
  logic          nuevo_q, nuevo_d;
  logic          reinicio_q, reinicio_d;
  logic          inicio_edge, ciclo_edge;

  assign inicio_edge = btnInicio & ~btn_prev_q;
  assign ciclo_edge  = ciclo & ~ciclo_prev_q;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score_d    = score_q;
    rec_d      = rec_q;
    nuevo_d    = nuevo_q;
    reinicio_d = 1'b0;
    case (state_q)
      IDLE: begin
        score_d = 16'h0000;
        if (inicio_edge) begin
          state_d    = JUGANDO;
          reinicio_d = 1'b1;
        end
      end
      JUGANDO: begin
        if (chocar) begin
          state_d = CHOQUE;
          cnt_d   = '0;
        end else if (ciclo_edge && score_q != 16'h9999) begin
          score_d = bcd_inc(score_q);
        end
      end
      CHOQUE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
          // Packed BCD digits order the same as their decimal values,
          // so a plain unsigned compare is the MSD-first digit compare.
          if (score_q > rec_q) begin
            rec_d   = score_q;
            nuevo_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        if (inicio_edge) begin
          state_d = IDLE;
          score_d = 16'h0000;
          nuevo_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      btn_prev_q   <= 1'b1;
      ciclo_prev_q <= 1'b1;
      cnt_q        <= '0;
      score_q      <= 16'h0000;
      rec_q        <= 16'h0000;
      nuevo_q      <= 1'b0;
      reinicio_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      btn_prev_q   <= btnInicio;
      ciclo_prev_q <= ciclo;
      cnt_q        <= cnt_d;
      score_q      <= score_d;
      rec_q        <= rec_d;
      nuevo_q      <= nuevo_d;
      reinicio_q   <= reinicio_d;
    end
  end

  assign estado         = state_q;
  assign congelar       = (state_q != JUGANDO);
  assign reinicioJuego  = reinicio_q;
  assign unidades       = score_q[3:0];
  assign decenas        = score_q[7:4];
  assign centenas       = score_q[11:8];
  assign unidadesMillar = score_q[15:12];
  assign recU           = rec_q[3:0];
  assign recD           = rec_q[7:4];
  assign recC           = rec_q[11:8];
  assign recM           = rec_q[15:12];
  assign nuevoRecord    = nuevo_q;

endmodule

// File: tb/tb_control_partida.sv
// Bench for control_partida: vector table, directed game sequences and random play against an integer model.
module tb_control_partida;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset, btnInicio, ciclo, chocar;
  logic [1:0] estado;
  logic       congelar, reinicioJuego, nuevoRecord;
  logic [3:0] unidades, decenas, centenas, unidadesMillar;
  logic [3:0] recU, recD, recC, recM;

  control_partida #(.T_CHOQUE(T), .CW(3)) dut (
    .clk(clk), .reset(reset), .btnInicio(btnInicio), .ciclo(ciclo), .chocar(chocar),
    .estado(estado), .congelar(congelar), .reinicioJuego(reinicioJuego),
    .unidades(unidades), .decenas(decenas), .centenas(centenas), .unidadesMillar(unidadesMillar),
    .recU(recU), .recD(recD), .recC(recC), .recM(recM), .nuevoRecord(nuevoRecord)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain integers for the game mode, score and record.
  int m_state = 0, m_score = 0, m_rec = 0, m_hold = 0, m_nuevo = 0, m_rein = 0;
  int m_bprev = 1, m_cprev = 1;

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_update(input logic r, input logic b, input logic c, input logic h);
    bit ie, ce;
    if (!r) begin
      m_state = 0; m_score = 0; m_rec = 0; m_hold = 0; m_nuevo = 0; m_rein = 0;
      m_bprev = 1; m_cprev = 1;
    end else begin
      ie = b && (m_bprev == 0);
      ce = c && (m_cprev == 0);
      m_rein = 0;
      case (m_state)
        0: begin
          m_score = 0;
          if (ie) begin m_state = 1; m_rein = 1; end
        end
        1: begin
          if (h) begin m_state = 2; m_hold = 0; end
          else if (ce && m_score < 9999) m_score++;
        end
        2: begin
          if (m_hold == T - 1) begin
            m_state = 3;
            if (m_score > m_rec) begin m_rec = m_score; m_nuevo = 1; end
          end else m_hold++;
        end
        default: begin
          if (ie) begin m_state = 0; m_score = 0; m_nuevo = 0; end
        end
      endcase
      m_bprev = b;
      m_cprev = c;
    end
  endtask

  function automatic int dut_score();
    return int'({unidadesMillar, centenas, decenas, unidades});
  endfunction

  function automatic int dut_rec();
    return int'({recM, recC, recD, recU});
  endfunction

  task automatic check_model();
    chk("estado", int'(estado), m_state);
    chk("congelar", int'(congelar), (m_state != 1) ? 1 : 0);
    chk("reinicioJuego", int'(reinicioJuego), m_rein);
    chk("score", dut_score(), to_bcd(m_score));
    chk("record", dut_rec(), to_bcd(m_rec));
    chk("nuevoRecord", int'(nuevoRecord), m_nuevo);
  endtask

  task automatic step(input logic r, input logic b, input logic c, input logic h);
    reset = r; btnInicio = b; ciclo = c; chocar = h;
    model_update(r, b, c, h);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < hi; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < lo; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic r, b, c, h;
    int   est, rein, score, rec, nue;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic rb, rc, rh;
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 'h0000, 'h0000, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 'h0000, 'h0000, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 'h0000, 'h0000, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 'h0000, 'h0000, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 'h0000, 'h0000, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 'h0000, 'h0000, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 'h0001, 'h0000, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 'h0001, 'h0000, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 'h0001, 'h0000, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 0, 'h0001, 'h0000, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 'h0001, 'h0000, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 'h0001, 'h0000, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 'h0001, 'h0000, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 'h0001, 'h0001, 1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 'h0000, 'h0001, 0};

    reset = 1'b0; btnInicio = 1'b1; ciclo = 1'b0; chocar = 1'b0;
    #2;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].b, tbl[i].c, tbl[i].h);
      chk($sformatf("tbl%0d_estado", i), int'(estado), tbl[i].est);
      chk($sformatf("tbl%0d_rein", i), int'(reinicioJuego), tbl[i].rein);
      chk($sformatf("tbl%0d_score", i), dut_score(), tbl[i].score);
      chk($sformatf("tbl%0d_rec", i), dut_rec(), tbl[i].rec);
      chk($sformatf("tbl%0d_nuevo", i), int'(nuevoRecord), tbl[i].nue);
    end

    // Start held through reset must not fire; a fresh press starts the game.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("held_start_idle", int'(estado), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_estado", int'(estado), 1);
    chk("start_pulse", int'(reinicioJuego), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_pulse_end", int'(reinicioJuego), 0);

    pulses(12, 3, 3);
    chk("score_12", dut_score(), 'h0012);

    // Collision coinciding with a tube edge: no point, then T cycles in CHOQUE.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("crash_estado", int'(estado), 2);
    chk("crash_score", dut_score(), 'h0012);
    for (int k = 1; k < T; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("hold_%0d", k), int'(estado), 2);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fin_estado", int'(estado), 3);
    chk("fin_record", dut_rec(), 'h0012);
    chk("fin_nuevo", int'(nuevoRecord), 1);

    // Second, lower game keeps the record.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("fin_to_idle", int'(estado), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("game2_start", int'(estado), 1);
    pulses(5, 1, 1);
    chk("score_5", dut_score(), 'h0005);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < T; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("game2_fin", int'(estado), 3);
    chk("game2_record", dut_rec(), 'h0012);
    chk("game2_nuevo", int'(nuevoRecord), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("game2_idle", int'(estado), 0);
    chk("game2_clear", dut_score(), 'h0000);

    // Reset in the middle of CHOQUE wipes the record as well.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_choque", int'(estado), 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_estado", int'(estado), 0);
    chk("rst_record", dut_rec(), 'h0000);
    chk("rst_congelar", int'(congelar), 1);

    // Saturation at 9999.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    pulses(9998, 1, 1);
    chk("score_9998", dut_score(), 'h9998);
    pulses(3, 1, 1);
    chk("score_sat", dut_score(), 'h9999);

    // Random play.
    rb = 1'b0; rc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      if ($urandom_range(0, 2) == 0) rc = ~rc;
      rh = ($urandom_range(0, 19) == 0);
      step(($urandom_range(0, 299) != 0), rb, rc, rh);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/control_partida.md
# control_partida

Game-flow controller for the bird-and-tubes VGA game. It consumes the collision flag and the tube-passed pulse from the game datapath, plus the debounced start button. It produces the run/freeze control, a one-cycle restart pulse, the BCD score for the 7-segment driver, and a persistent high score. It sits downstream of the collision comparator and tube FSM, and upstream of the 7-segment controller and the drawing block's clear input.

## Interface

- T_CHOQUE, default 50_000_000: clock cycles held in CHOQUE before entering FIN (1 s at 50 MHz).
- CW, default 26: width of the CHOQUE hold counter; must satisfy 2^CW > T_CHOQUE.

- clk, in, 1: master clock, 50 MHz.
- reset, in, 1: synchronous, active-low reset.
- btnInicio, in, 1: debounced start button, level.
- ciclo, in, 1: tube-passed indication, level; each rising edge is one point.
- chocar, in, 1: collision flag, level.
- estado, out, 2: current state (00 IDLE, 01 JUGANDO, 10 CHOQUE, 11 FIN).
- congelar, out, 1: 1 whenever estado != JUGANDO.
- reinicioJuego, out, 1: one-cycle pulse on the IDLE->JUGANDO transition.
- unidades, decenas, centenas, unidadesMillar, out, 4 each: current score, BCD.
- recU, recD, recC, recM, out, 4 each: high score, BCD.
- nuevoRecord, out, 1: high in FIN when the last game set a new record.

## Operation

- Edge detectors: registered copies btnPrev and cicloPrev.
  - Both reset to 1, so an input held high through reset does not fire.
  - inicioEdge = btnInicio & ~btnPrev.
  - cicloEdge = ciclo & ~cicloPrev.
- IDLE:
  - Score is held at 0000.
  - inicioEdge moves to JUGANDO and asserts reinicioJuego for that one cycle.
- JUGANDO:
  - cicloEdge increments the score as a 4-digit BCD ripple (9->0 with carry) and saturates at 9999.
  - chocar=1 moves to CHOQUE. Collision has priority: if chocar and cicloEdge coincide, there is no increment.
  - btnInicio is ignored.
- CHOQUE:
  - The hold counter loads 0 on entry and increments each cycle.
  - When the counter reaches T_CHOQUE-1, the next edge:
    - goes to FIN;
    - if score > record (4-digit BCD magnitude compare, most significant digit first), copies the score into the record and sets nuevoRecord.
  - All inputs are ignored in CHOQUE.
- FIN:
  - Score and record are held.
  - inicioEdge moves to IDLE, clears the score to 0000, and clears nuevoRecord.
- The record survives game restarts; only reset clears it.
- All outputs are registered. congelar is decoded from the state register; no combinational path runs from any input to any output.

## Timing

- Reset values (reset=0 at an edge):
  - estado=00, congelar=1, reinicioJuego=0, nuevoRecord=0.
  - All score and record digits = 0.
  - Hold counter = 0; btnPrev=1, cicloPrev=1.
- Edge-detection latency:
  - Input rises before edge k (prev=0) → state and score update at edge k.
  - Outputs are visible after edge k, i.e. 1 cycle after the input rises.
- reinicioJuego:
  - High exactly one cycle, coincident with the first cycle of estado=01.
- CHOQUE duration:
  - Exactly T_CHOQUE cycles from the first cycle of estado=10 to the first cycle of estado=11.
  - The record update and nuevoRecord are visible in the first FIN cycle.
- Boundary cases:
  - Saturation: at score 9999, further cicloEdge events leave the score unchanged.
  - Equal score: a score equal to the record does not update it, and nuevoRecord stays 0.
  - Reset mid-game: reset in any state returns to the reset values on that edge, including the record.
  - Held button: a continuously held btnInicio produces only one transition; it must fall and rise again to leave FIN and again to start the next game.

## Test plan

Benches use T_CHOQUE=4.

1. Reset with btnInicio held high, then release reset → estado stays 00. Drop btnInicio, then raise it → estado=01 and reinicioJuego is high for exactly one cycle.
2. In JUGANDO, apply 12 ciclo pulses (each ciclo 3 cycles high, 3 low) → score reads 0012 (unidades=2, decenas=1).
3. In JUGANDO, raise chocar in the same cycle as a ciclo rising edge → score unchanged and estado=10. FIN is reached exactly 4 cycles later, with record=0012 and nuevoRecord=1.
4. Second game: score 0005, then crash → record stays 0012 and nuevoRecord=0. Then press start → estado=00 and score=0000.
5. Preload the score to 9998 (by 9998 pulses, or force) and apply 3 ciclo pulses → score=9999 and holds.
6. Assert reset during CHOQUE with record=0012 → next cycle estado=00, record=0000, congelar=1.
